// File: rtl/fx2fp_pkg.sv
// Shared types and defaults for the fixed-point to IEEE-754 converter.
// Imported by the rounding stage and the converter top.
package fx2fp_pkg;

    localparam int EW_D   = 8;
    localparam int SW_D   = 23;
    localparam int BIAS_D = 127;

    localparam int FLT_W     = 1 + EW_D + SW_D;
    localparam int FLT_SIGN  = FLT_W - 1;
    localparam int FLT_EXP_L = SW_D;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        ABS       = 3'd2,
        NORM      = 3'd3,
        ROUND     = 3'd4,
        ROUND_OVF = 3'd5,
        PACK      = 3'd6,
        READY     = 3'd7
    } state_t;

endpackage

// File: rtl/fx2fp_round.sv
// Round-to-nearest-even of a normalized magnitude (leading one dropped).
// Produces stored mantissa, carry-out, guard and sticky.
module fx2fp_round
    import fx2fp_pkg::*;
#(
    parameter int W  = 32,
    parameter int SW = SW_D
) (
    input  logic [W-2:0]  i_mag,
    output logic [SW-1:0] o_mant,
    output logic          o_ovf,
    output logic          o_grd,
    output logic          o_stk
);

    logic [SW-1:0] w_m;
    logic          w_inc;
    logic [SW+1:0] w_sum;

    assign w_m   = i_mag[W-2 -: SW];
    assign o_grd = i_mag[W-2-SW];
    assign o_stk = |i_mag[W-3-SW:0];
    assign w_inc = o_grd & (o_stk | w_m[0]);

    assign w_sum = {2'b01, w_m} + {{(SW+1){1'b0}}, w_inc};

    assign o_mant = w_sum[SW-1:0];
    // Carry either lands in the top bit or leaves the hidden bit clear.
    assign o_ovf  = w_sum[SW+1] | ~w_sum[SW];

endmodule

// File: rtl/fixed_to_float_conv.sv
// Multi-cycle signed fixed-point to IEEE-754 converter with
// beg_FSM / ready / rst_FSM handshake.
module fixed_to_float_conv
    import fx2fp_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int EW   = EW_D,
    parameter int SW   = SW_D,
    parameter int BIAS = BIAS_D
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            beg_FSM,
    input  logic            rst_FSM,
    input  logic [W-1:0]    fixed_i,
    output logic [EW+SW:0]  result_o,
    output logic            zero_flag_o,
    output logic            inexact_o,
    output logic            ready
);

    localparam int XW       = EW + 1;
    localparam int EXP_INIT = BIAS + W - 1 - FRAC;

    localparam logic [W-1:0]  MAG_ONE  = W'(1);
    localparam logic [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic [XW-1:0] EXP_INIT_V = XW'(EXP_INIT);

    state_t r_state;
    state_t w_next;

    logic          r_sign;
    logic          r_zero;
    logic          r_grd;
    logic          r_stk;
    logic [W-1:0]  r_mag;
    logic [XW-1:0] r_exp;
    logic [SW-1:0] r_mant;

    logic [SW-1:0] w_mant;
    logic          w_ovf;
    logic          w_grd;
    logic          w_stk;
    logic [EW-1:0] w_exp_fld;

    fx2fp_round #(
        .W  (W),
        .SW (SW)
    ) u_round (
        .i_mag  (r_mag[W-2:0]),
        .o_mant (w_mant),
        .o_ovf  (w_ovf),
        .o_grd  (w_grd),
        .o_stk  (w_stk)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:      w_next = beg_FSM ? LOAD : IDLE;
            LOAD:      w_next = ABS;
            ABS:       w_next = (r_mag == '0) ? PACK : NORM;
            NORM:      w_next = r_mag[W-1] ? ROUND : NORM;
            ROUND:     w_next = w_ovf ? ROUND_OVF : PACK;
            ROUND_OVF: w_next = PACK;
            PACK:      w_next = READY;
            READY:     w_next = rst_FSM ? IDLE : READY;
            default:   w_next = IDLE;
        endcase
    end

    // Exponent cannot go negative within the legal parameter range.
    assign w_exp_fld = r_exp[EW] ? '0 : r_exp[EW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_grd       <= 1'b0;
            r_stk       <= 1'b0;
            r_mag       <= '0;
            r_exp       <= '0;
            r_mant      <= '0;
            result_o    <= '0;
            zero_flag_o <= 1'b0;
            inexact_o   <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_sign <= fixed_i[W-1];
                    r_mag  <= fixed_i;
                    r_grd  <= 1'b0;
                    r_stk  <= 1'b0;
                    r_mant <= '0;
                end
                ABS: begin
                    r_mag  <= r_sign ? (~r_mag + MAG_ONE) : r_mag;
                    r_exp  <= EXP_INIT_V;
                    r_zero <= (r_mag == '0);
                end
                NORM: begin
                    if (!r_mag[W-1]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - EXP_ONE;
                    end
                end
                ROUND: begin
                    r_mant <= w_mant;
                    r_grd  <= w_grd;
                    r_stk  <= w_stk;
                end
                ROUND_OVF: begin
                    r_mant <= '0;
                    r_exp  <= r_exp + EXP_ONE;
                end
                PACK: begin
                    result_o    <= r_zero ? '0 : {r_sign, w_exp_fld, r_mant};
                    zero_flag_o <= r_zero;
                    inexact_o   <= r_grd | r_stk;
                end
                default: ;
            endcase
        end
    end

    assign ready = (r_state == READY);

endmodule

// File: tb/tb_fixed_to_float_conv.sv
// Bench for fixed_to_float_conv: directed table, random vs. arithmetic model,
// handshake and asynchronous reset sequences.
module tb_fixed_to_float_conv;

    localparam int W    = 32;
    localparam int FRAC = 16;
    localparam int EW   = 8;
    localparam int SW   = 23;
    localparam int BIAS = 127;

    logic          clk = 1'b0;
    logic          rst;
    logic          beg_FSM;
    logic          rst_FSM;
    logic [W-1:0]  fixed_i;
    logic [31:0]   result_o;
    logic          zero_flag_o;
    logic          inexact_o;
    logic          ready;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] res;
        logic        z;
        logic        ix;
        int          lat;
    } vec_t;

    vec_t tbl [10];

    fixed_to_float_conv #(
        .W    (W),
        .FRAC (FRAC),
        .EW   (EW),
        .SW   (SW),
        .BIAS (BIAS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .beg_FSM     (beg_FSM),
        .rst_FSM     (rst_FSM),
        .fixed_i     (fixed_i),
        .result_o    (result_o),
        .zero_flag_o (zero_flag_o),
        .inexact_o   (inexact_o),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: exact magnitude, msb search, integer RNE on the remainder.
    task automatic model(input logic [31:0] x, output logic [31:0] res,
                         output logic z, output logic ix, output int lat);
        longint mag, q, rem, half;
        int     p, e, sh;
        logic   s;
        s   = x[31];
        mag = longint'($signed(x));
        if (mag < 0) mag = -mag;
        res = '0; z = 1'b0; ix = 1'b0; lat = 0;
        if (mag == 0) begin
            z   = 1'b1;
            lat = 3;
        end else begin
            p = 62;
            while (((mag >> p) & 1) == 0) p--;
            e = BIAS + p - FRAC;
            if (p > SW) begin
                sh   = p - SW;
                q    = mag >> sh;
                rem  = mag - (q << sh);
                half = longint'(1) << (sh - 1);
                ix   = (rem != 0);
                if (rem > half || (rem == half && (q % 2) == 1)) q++;
            end else begin
                q = mag << (SW - p);
            end
            lat = 5 + (W - 1 - p);
            if (q == (longint'(1) << (SW + 1))) begin
                q = q >> 1;
                e++;
                lat++;
            end
            res = {s, e[7:0], q[22:0]};
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) fixed_i = $urandom;
        end
    endtask

    task automatic run(input logic [31:0] x, input logic [31:0] er,
                       input logic ez, input logic eix, input int elat,
                       input string nm);
        int n;
        @(negedge clk);
        fixed_i = x;
        beg_FSM = 1'b1;
        @(posedge clk);
        #1 beg_FSM = 1'b0;
        wait_ready(n);
        chk({nm, " latency"}, n, elat);
        chk({nm, " result"}, result_o, er);
        chk({nm, " zero"}, {31'd0, zero_flag_o}, {31'd0, ez});
        chk({nm, " inexact"}, {31'd0, inexact_o}, {31'd0, eix});
        // beg_FSM alone is ignored while READY
        @(negedge clk);
        beg_FSM = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, " hold ready"}, {31'd0, ready}, 32'd1);
        @(negedge clk);
        beg_FSM = 1'b0;
        rst_FSM = 1'b1;
        @(posedge clk);
        #1 rst_FSM = 1'b0;
        chk({nm, " release"}, {31'd0, ready}, 32'd0);
        chk({nm, " idle hold"}, result_o, er);
    endtask

    initial begin
        logic [31:0] x, er;
        logic        ez, eix;
        int          el, n;

        tbl[0] = '{32'h0001_0000, 32'h3F80_0000, 1'b0, 1'b0, 20};
        tbl[1] = '{32'hFFFE_8000, 32'hBFC0_0000, 1'b0, 1'b0, 20};
        tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 3};
        tbl[3] = '{32'h7FFF_FFFF, 32'h4700_0000, 1'b0, 1'b1, 7};
        tbl[4] = '{32'h4000_0040, 32'h4680_0000, 1'b0, 1'b1, 6};
        tbl[5] = '{32'h4000_00C0, 32'h4680_0002, 1'b0, 1'b1, 6};
        tbl[6] = '{32'h8000_0000, 32'hC700_0000, 1'b0, 1'b0, 5};
        tbl[7] = '{32'h0000_0001, 32'h3780_0000, 1'b0, 1'b0, 36};
        tbl[8] = '{32'hFFFF_FFFF, 32'hB780_0000, 1'b0, 1'b0, 36};
        tbl[9] = '{32'h0001_0000, 32'h3F80_0000, 1'b0, 1'b0, 20};

        rst     = 1'b1;
        beg_FSM = 1'b0;
        rst_FSM = 1'b0;
        fixed_i = '0;
        #2 rst = 1'b0;
        #1;
        chk("reset result", result_o, 32'h0);
        chk("reset flags", {29'd0, zero_flag_o, inexact_o, ready}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run(tbl[i].x, tbl[i].res, tbl[i].z, tbl[i].ix, tbl[i].lat,
                $sformatf("dir%0d", i));
        end

        for (int i = 0; i < 250; i++) begin
            x = $urandom;
            x = $signed(x) >>> $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) x = '0;
            model(x, er, ez, eix, el);
            run(x, er, ez, eix, el, $sformatf("rnd%0d x=%h", i, x));
        end

        // beg_FSM and rst_FSM together in READY: release wins, then restart
        @(negedge clk);
        fixed_i = 32'h8000_0000;
        beg_FSM = 1'b1;
        @(posedge clk);
        #1 beg_FSM = 1'b0;
        wait_ready(n);
        chk("both lat0", n, 32'd5);
        @(negedge clk);
        fixed_i = 32'h0001_0000;
        beg_FSM = 1'b1;
        rst_FSM = 1'b1;
        @(posedge clk);
        #1 rst_FSM = 1'b0;
        chk("both release", {31'd0, ready}, 32'd0);
        chk("both held", result_o, 32'hC700_0000);
        @(posedge clk);
        #1 beg_FSM = 1'b0;
        wait_ready(n);
        chk("both lat1", n, 32'd20);
        chk("both result", result_o, 32'h3F80_0000);
        @(negedge clk);
        rst_FSM = 1'b1;
        @(posedge clk);
        #1 rst_FSM = 1'b0;

        // asynchronous reset during NORM
        @(negedge clk);
        fixed_i = 32'h0000_0001;
        beg_FSM = 1'b1;
        @(posedge clk);
        #1 beg_FSM = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst result", result_o, 32'h0);
        chk("arst flags", {29'd0, zero_flag_o, inexact_o, ready}, 32'h0);
        beg_FSM = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst beg ignored", {31'd0, ready}, 32'd0);
        chk("arst still zero", result_o, 32'h0);
        @(negedge clk);
        beg_FSM = 1'b0;
        rst = 1'b1;
        run(32'hFFFE_8000, 32'hBFC0_0000, 1'b0, 1'b0, 20, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
